display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Sequences the 4-digit multiplexed 7-segment display. Per digit it runs a dwell timer and inserts a blanking gap before each digit to suppress ghosting. Incoming 32-bit frames are double-buffered, and new content takes effect only on a frame boundary. It sits between the digit-pattern producers (decod7seg instances) and the board pins (AN0..AN3, segment bus), replacing the free-running 2-bit counter, 2x4 decoder and display mux path.

Parameters:
SCAN_DIV, 250000, total CCLK cycles per digit slot (blank + show); must be > BLANK_CYC
BLANK_CYC, 500, CCLK cycles per slot with all anodes off; must be >= 1
DIM_BITS, 4, width of brightness duty/PWM counter (used only with DISP_DIMMING_EN)

Ports:
CCLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
load  in  1  request to accept new frame
load_ready  out  1  frame can be accepted this cycle; transfer when load & load_ready
frame_in  in  32  digit patterns; [7:0]=digit0 ... [31:24]=digit3; bit order a,b,c,d,e,f,g,dp; active-low
en_in  in  4  per-digit enable, captured with frame_in
duty  in  DIM_BITS  brightness (present only with DISP_DIMMING_EN)
AN0..AN3  out  1 each  digit anodes, active-low
SEG  out  8  segment bus to pins, active-low
frame_tick  out  1  one-cycle pulse at start of every frame (digit 0 blank phase)

Behaviour:
- All outputs registered. Reset (RST_N=0 at a CCLK edge) forces:
  - AN0..AN3 = 1, SEG = 8'hFF, frame_tick = 0, load_ready = 1.
  - Shadow patterns = 8'hFF x4, shadow enables = 4'b0000, pending empty.
  - digit index = 0, state = BLANK, slot counter = 0.
- Reset asserted mid-frame aborts immediately. A pending frame is discarded.
- FSM, per slot:
  - BLANK: BLANK_CYC cycles; all AN = 1, SEG = 8'hFF.
  - SHOW: SCAN_DIV-BLANK_CYC cycles.
    - AN[idx] = ~shadow_en[idx]; other anodes = 1.
    - SEG = shadow[idx] if enabled, else 8'hFF.
  - At end of SHOW, idx increments and wraps 3->0, then return to BLANK.
- Slot counter runs 0..SCAN_DIV-1. BLANK ends when counter = BLANK_CYC-1.
- Outputs reflect the state with one-cycle register latency from the state change.
- frame_tick is high for the first cycle of BLANK when idx = 0, including the first slot after reset release.
- Handshake:
  - load_ready = ~pending_valid.
  - On load & load_ready: frame_in/en_in go into the pending register; pending_valid = 1.
  - load with load_ready = 0 is ignored; no stall, no error.
  - frame_in is don't-care when load is low.
- Commit: on the last SHOW cycle of digit 3, if pending_valid:
  - pending copies to shadow; pending_valid clears.
  - load_ready returns high the next cycle.
  - A load presented in the commit cycle is not accepted (load_ready still 0).
- Shadow never changes mid-frame. All four digits of a frame are always from the same load.
- Back-to-back loads: the second is held off until the first commits (at most 1 frame + 1 cycle).

Optional Feature:
DISP_DIMMING_EN.
- With macro:
  - The duty port exists.
  - A free-running DIM_BITS PWM counter runs during SHOW.
  - The enabled anode is driven low only when pwm_cnt < duty. duty = 0 gives a dark display; max gives (2^DIM_BITS-1)/2^DIM_BITS.
  - SEG still follows the shadow pattern.
  - duty is sampled live; no buffering.
- Without macro: no duty port, no PWM counter; the anode is low for the entire SHOW phase.

Decomposition:
- Shared package disp_pkg:
  - NUM_DIGITS = 4
  - SEG_OFF = 8'hFF
  - AN_OFF = 4'b1111
  - state encoding BLANK/SHOW
  - frame field slice offsets
- One sub-module: scan_timer.
  - Slot counter with SCAN_DIV/BLANK_CYC compares.
  - Outputs blank_done and slot_done strobes.
- The FSM, handshake and shadow registers stay in display_scan_ctrl.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2.
1. Reset then run 40 cycles -> AN all 1, SEG=FF throughout; frame_tick pulses at cycles 1 and 33 after release.
2. Load frame 0x0102_0304, en=4'hF, before first frame -> next frame shows:
   - digit0 SEG=04, AN0=0 for 6 cycles after 2 blank cycles.
   - digits 1..3 show 03, 02, 01 in turn.
3. Load A mid-frame, then hold load high with B -> load_ready=0 until the cycle after the digit-3 last SHOW; A is displayed that frame; B accepted next cycle and displayed one frame later.
4. en_in=4'b0101 -> AN1/AN3 never low, SEG=FF during their SHOW slots.
5. Assert RST_N=0 during digit 2 SHOW with a pending frame -> next cycle AN all 1, SEG=FF, load_ready=1; pending never displayed.
6. (DISP_DIMMING_EN) duty=4 -> AN0 low in exactly 4 of every 16 SHOW cycles; duty=0 -> no anode ever low.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [DIGIT_W-1:0]    SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Bit offset of a digit's pattern inside the 32-bit frame word.
  function automatic int unsigned digit_lsb(input logic [IDX_W-1:0] d);
    return int'(d) * DIGIT_W;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Per-digit slot counter (0..SCAN_DIV-1) with blank-end and slot-end strobes.
module scan_timer #(
  parameter int unsigned SCAN_DIV  = 250000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start,
  output logic blank_done,
  output logic slot_done
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)         cnt <= '0;
    else if (slot_done) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

  assign slot_start = (cnt == '0);
  assign blank_done = (cnt == CW'(BLANK_CYC - 1));
  assign slot_done  = (cnt == CW'(SCAN_DIV - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit display scanner: blank/show slot FSM, double-buffered frames, registered pins.
// Optional brightness PWM on the anodes when DISP_DIMMING_EN is defined.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 250000,
  parameter int unsigned BLANK_CYC = 500
`ifdef DISP_DIMMING_EN
  , parameter int unsigned DIM_BITS = 4
`endif
) (
  input  logic        CCLK,
  input  logic        RST_N,
  input  logic        load,
  output logic        load_ready,
  input  logic [31:0] frame_in,
  input  logic [3:0]  en_in,
`ifdef DISP_DIMMING_EN
  input  logic [DIM_BITS-1:0] duty,
`endif
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic [7:0]  SEG,
  output logic        frame_tick
);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [31:0]             shadow, pending;
  logic [NUM_DIGITS-1:0]   shadow_en, pending_en;
  logic                    pending_valid;
  logic                    slot_start, blank_done, slot_done;
  logic                    commit, lit;
  logic [NUM_DIGITS-1:0]   an_q, an_nxt;
  logic [DIGIT_W-1:0]      seg_nxt;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (CCLK),
    .rst_n      (RST_N),
    .slot_start (slot_start),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

`ifdef DISP_DIMMING_EN
  logic [DIM_BITS-1:0] pwm_cnt;

  always_ff @(posedge CCLK) begin
    if (!RST_N)              pwm_cnt <= '0;
    else if (state == SHOW)  pwm_cnt <= pwm_cnt + DIM_BITS'(1);
  end

  assign lit = (pwm_cnt < duty);
`else
  assign lit = 1'b1;
`endif

  // Frame boundary: last SHOW cycle of the final digit.
  assign commit = (state == SHOW) && slot_done && (idx == IDX_W'(NUM_DIGITS - 1)) && pending_valid;
  assign load_ready = ~pending_valid;

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (state == SHOW && shadow_en[idx]) begin
      seg_nxt     = shadow[digit_lsb(idx) +: DIGIT_W];
      an_nxt[idx] = ~lit;
    end
  end

  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      state         <= BLANK;
      idx           <= '0;
      shadow        <= {NUM_DIGITS{SEG_OFF}};
      shadow_en     <= '0;
      pending       <= '1;
      pending_en    <= '0;
      pending_valid <= 1'b0;
      an_q          <= AN_OFF;
      SEG           <= SEG_OFF;
      frame_tick    <= 1'b0;
    end else begin
      if (state == BLANK) begin
        if (blank_done) state <= SHOW;
      end else if (slot_done) begin
        state <= BLANK;
        idx   <= idx + IDX_W'(1);
      end

      if (commit) begin
        shadow        <= pending;
        shadow_en     <= pending_en;
        pending_valid <= 1'b0;
      end else if (load && !pending_valid) begin
        pending       <= frame_in;
        pending_en    <= en_in;
        pending_valid <= 1'b1;
      end

      an_q       <= an_nxt;
      SEG        <= seg_nxt;
      frame_tick <= (state == BLANK) && slot_start && (idx == '0);
    end
  end

  assign {AN3, AN2, AN1, AN0} = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a cycle-count reference model.
module tb_display_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic        CCLK = 1'b0;
  logic        RST_N;
  logic        load;
  logic        load_ready;
  logic [31:0] frame_in;
  logic [3:0]  en_in;
  logic        AN0, AN1, AN2, AN3;
  logic [7:0]  SEG;
  logic        frame_tick;
`ifdef DISP_DIMMING_EN
  logic [3:0]  duty;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release, buffers, PWM phase.
  int          k;
  bit          pend_v;
  logic [31:0] pend_f, sh_f;
  logic [3:0]  pend_e, sh_e;
  int          pwm;

  display_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .CCLK       (CCLK),
    .RST_N      (RST_N),
    .load       (load),
    .load_ready (load_ready),
    .frame_in   (frame_in),
    .en_in      (en_in),
`ifdef DISP_DIMMING_EN
    .duty       (duty),
`endif
    .AN0        (AN0),
    .AN1        (AN1),
    .AN2        (AN2),
    .AN3        (AN3),
    .SEG        (SEG),
    .frame_tick (frame_tick)
  );

  always #5 CCLK = ~CCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @k=%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Applies one clock edge with the inputs already driven, then compares outputs.
  task automatic step();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_tick;
    logic       on;
    int         pos, di;
    bit         show;
    e_an  = 4'hF;
    e_seg = 8'hFF;
    e_tick = 1'b0;
    if (!RST_N) begin
      k = 0; pend_v = 0; sh_f = '1; sh_e = '0; pwm = 0;
    end else begin
      pos    = k % SCAN_DIV;
      di     = (k / SCAN_DIV) % 4;
      show   = (pos >= BLANK_CYC);
      e_tick = ((k % FRAME) == 0);
`ifdef DISP_DIMMING_EN
      on = ((pwm % 16) < int'(duty));
`else
      on = 1'b1;
`endif
      if (show && sh_e[di]) begin
        e_seg    = sh_f[di*8 +: 8];
        e_an[di] = ~on;
      end
      if (show) pwm++;
      if (pend_v && (k % FRAME) == FRAME - 1) begin
        sh_f = pend_f; sh_e = pend_e; pend_v = 0;
      end else if (load && !pend_v) begin
        pend_f = frame_in; pend_e = en_in; pend_v = 1;
      end
      k++;
    end
    @(posedge CCLK);
    #1;
    check("an",    {28'd0, AN3, AN2, AN1, AN0}, {28'd0, e_an});
    check("seg",   {24'd0, SEG}, {24'd0, e_seg});
    check("tick",  {31'd0, frame_tick}, {31'd0, e_tick});
    check("ready", {31'd0, load_ready}, {31'd0, ~pend_v});
    @(negedge CCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      load = 1'b0;
      frame_in = $urandom;
      en_in = 4'($urandom);
      step();
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    load  = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    load = 1'b0;
    frame_in = '0;
    en_in = '0;
`ifdef DISP_DIMMING_EN
    duty = 4'd4;
`endif
    k = 0; pend_v = 0; pend_f = '1; pend_e = '0; sh_f = '1; sh_e = '0; pwm = 0;
    @(negedge CCLK);
    step();
    do_reset();

    // Blank display after reset.
    idle(40);

    // First frame loaded right after reset.
    do_reset();
    load = 1'b1; frame_in = 32'h0102_0304; en_in = 4'hF;
    step();
    idle(70);

    // Load A mid-frame, then hold load high with B.
    idle(12);
    load = 1'b1; frame_in = 32'hA1A2_A3A4; en_in = 4'hF;
    step();
    for (int i = 0; i < 80; i++) begin
      load = 1'b1; frame_in = 32'hB1B2_B3B4; en_in = 4'hF;
      step();
    end
    idle(40);

    // Partial digit enables.
    load = 1'b1; frame_in = 32'h1122_3344; en_in = 4'b0101;
    step();
    idle(70);

    // Reset during digit 2 SHOW with a frame pending.
    while ((k % FRAME) != 16) idle(1);
    load = 1'b1; frame_in = 32'hDEAD_BEEF; en_in = 4'hF;
    step();
    while ((k % FRAME) != 20) idle(1);
    do_reset();
    idle(70);

`ifdef DISP_DIMMING_EN
    duty = 4'd0;
    load = 1'b1; frame_in = 32'h5566_7788; en_in = 4'hF;
    step();
    idle(70);
    duty = 4'd4;
    idle(70);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      RST_N    = (($urandom % 300) != 0);
      load     = (($urandom % 4) == 0);
      frame_in = $urandom;
      en_in    = 4'($urandom);
`ifdef DISP_DIMMING_EN
      duty     = 4'($urandom);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
